dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single async-read, sync-write data memory between two requesters. Port 0 is the CPU load/store path; port 1 is the loader/debug DMA path.
- Round-robin arbitration between the two ports.
- RISC-V-style sub-word loads (sign/zero extension).
- Byte and halfword stores implemented as a two-cycle read-modify-write on the word-wide memory.
- Sits between requesters and the memory. The memory's address port takes a word index.

Parameters:
- DATA_WIDTH, 32, word width of memory and requester data.
- DEPTH_WORDS, 10001, number of memory words; word index >= DEPTH_WORDS is out of range.
- RR_EN, 1, 1 = round-robin; 0 = port 0 always has fixed priority.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pN_req  in  1  port N request (N = 0, 1; all pN_ signals duplicated per port)
- pN_we  in  1  1 = store, 0 = load
- pN_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only)
- pN_addr  in  32  byte address
- pN_wdata  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0])
- pN_gnt  out  1  request accepted this cycle
- pN_rdata  out  DATA_WIDTH  extended load data, valid when pN_gnt and load
- pN_err  out  1  misaligned, illegal funct3, or out-of-range; valid with pN_gnt
- mem_a  out  DATA_WIDTH  word index = granted addr[31:2]
- mem_we  out  1  memory write enable
- mem_wd  out  DATA_WIDTH  memory write data
- mem_rd  in  DATA_WIDTH  async read data from memory

Behaviour:
- FSM states: IDLE, RMW_WR. Reset → IDLE.
  - While rst_n low: all gnt, err, mem_we = 0; rdata = 0.
  - Round-robin pointer resets so port 0 wins the first tie.
- IDLE arbitration (combinational):
  - Winner = only requester, else per pointer (RR_EN=1) or port 0 (RR_EN=0).
  - At most one gnt per cycle. Pointer updates at the clock edge of every grant to favour the other port.
  - Loser holds req; it has no timeout.
- Load (IDLE): gnt same cycle, zero wait. mem_a = addr[31:2].
  - Byte lane = addr[1:0]; half lane = addr[1].
  - B/H sign-extend, BU/HU zero-extend, W passes the word through.
- Word store (IDLE): gnt same cycle. mem_we = 1, mem_wd = wdata. Memory written at that edge. Stay in IDLE.
- Byte/half store:
  - IDLE cycle: gnt = 1, mem_we = 0. At the edge, register word index and merged word (mem_rd with the selected lane(s) replaced by wdata). Go to RMW_WR.
  - RMW_WR cycle: mem_a = registered index, mem_we = 1, mem_wd = registered merged word. No gnt to either port. Return to IDLE.
  - Total two cycles; requester may drop req after gnt.
- Error cases: half with addr[0]=1, word with addr[1:0]≠0, funct3 011/11x, BU/HU with we=1, or addr[31:2] >= DEPTH_WORDS.
  - gnt = 1, err = 1, mem_we = 0, rdata = 0, no RMW entry.
  - Pointer still advances.
- Ordering: a load following an RMW store to the same word returns the merged data, because RMW_WR blocks all grants.
- Reset asserted in RMW_WR: immediate return to IDLE, mem_we drops combinationally, pending write discarded.
- No req in IDLE: mem_we = 0, mem_a = 0, pointer unchanged.

Test Plan:
- After reset, mem[5] = 0x11223344. p0 LW addr 0x14 → p0_gnt same cycle, p0_rdata = 0x11223344, p0_err = 0.
- mem[5] = 0x11223344. p1 SB addr 0x15, wdata 0xAB → gnt cycle has mem_we = 0; next cycle mem_we = 1, mem_wd = 0x1122AB44. Then LB 0x15 → 0xFFFFFFAB, LBU 0x15 → 0x000000AB.
- Both ports request LW every cycle for 4 cycles, RR_EN = 1 → grant order p0, p1, p0, p1. With RR_EN = 0 → p0 granted all 4.
- p0 SH addr 0x16 wdata 0xBEEF, p1 LW 0x14 asserted same cycle → p0 granted. RMW_WR cycle: p1_gnt = 0. Next cycle p1 reads 0xBEEFxxxx (merged).
- p0 LW addr 0x13 → err = 1, gnt = 1, mem_we = 0. p0 SW to word index 10001 → err = 1, memory unchanged.
- Reset pulsed low during RMW_WR → mem_we = 0 immediately, target word unchanged, FSM in IDLE after release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a word-wide async-read / sync-write data memory.
// Handles RISC-V sub-word loads and implements byte/half stores as read-modify-write.
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 10001,
  parameter bit          RR_EN       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [2:0]            p0_funct3,
  input  logic [31:0]           p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p0_err,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [2:0]            p1_funct3,
  input  logic [31:0]           p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_err,
  output logic [DATA_WIDTH-1:0] mem_a,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  typedef enum logic [0:0] {StIdle, StRmwWr} state_e;

  state_e                state_q, state_d;
  logic                  rr_q, rr_d;  // port favoured on the next tie
  logic [DATA_WIDTH-1:0] rmw_idx_q, rmw_idx_d;
  logic [DATA_WIDTH-1:0] rmw_data_q, rmw_data_d;

  logic                  win;
  logic                  s_we;
  logic [2:0]            s_f3;
  logic [31:0]           s_addr;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic [DATA_WIDTH-1:0] word_idx;
  logic                  in_range;
  logic                  s_err;
  logic [7:0]            ld_b;
  logic [15:0]           ld_h;
  logic [DATA_WIDTH-1:0] ld_ext;
  logic [DATA_WIDTH-1:0] merged;

  logic [1:0]                 gnt_v, err_v;
  logic [1:0][DATA_WIDTH-1:0] rdata_v;

  // Winner: sole requester, else the pointer (or port 0 with fixed priority).
  always_comb begin
    if (p0_req && p1_req) win = RR_EN ? rr_q : 1'b0;
    else                  win = p1_req;
  end

  assign s_we    = win ? p1_we     : p0_we;
  assign s_f3    = win ? p1_funct3 : p0_funct3;
  assign s_addr  = win ? p1_addr   : p0_addr;
  assign s_wdata = win ? p1_wdata  : p0_wdata;

  assign word_idx = {{(DATA_WIDTH-30){1'b0}}, s_addr[31:2]};
  assign in_range = ({2'b00, s_addr[31:2]} < DEPTH_WORDS);

  always_comb begin
    s_err = 1'b0;
    case (s_f3)
      3'b000:         s_err = 1'b0;
      3'b001:         s_err = s_addr[0];
      3'b010:         s_err = |s_addr[1:0];
      3'b100, 3'b101: s_err = s_we | (s_f3[0] & s_addr[0]);
      default:        s_err = 1'b1;
    endcase
    if (!in_range) s_err = 1'b1;
  end

  assign ld_b = mem_rd[{s_addr[1:0], 3'b000} +: 8];
  assign ld_h = mem_rd[{s_addr[1], 4'b0000} +: 16];

  always_comb begin
    case (s_f3)
      3'b000:  ld_ext = {{(DATA_WIDTH-8){ld_b[7]}}, ld_b};
      3'b001:  ld_ext = {{(DATA_WIDTH-16){ld_h[15]}}, ld_h};
      3'b100:  ld_ext = {{(DATA_WIDTH-8){1'b0}}, ld_b};
      3'b101:  ld_ext = {{(DATA_WIDTH-16){1'b0}}, ld_h};
      default: ld_ext = mem_rd;
    endcase
  end

  always_comb begin
    merged = mem_rd;
    if (s_f3 == 3'b000) merged[{s_addr[1:0], 3'b000} +: 8] = s_wdata[7:0];
    else                merged[{s_addr[1], 4'b0000} +: 16] = s_wdata[15:0];
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    rmw_idx_d  = rmw_idx_q;
    rmw_data_d = rmw_data_q;
    gnt_v      = '0;
    err_v      = '0;
    rdata_v    = '0;
    mem_a      = '0;
    mem_we     = 1'b0;
    mem_wd     = '0;
    case (state_q)
      StIdle: begin
        if (p0_req || p1_req) begin
          gnt_v[win] = 1'b1;
          rr_d       = ~win;
          mem_a      = word_idx;
          if (s_err) begin
            err_v[win] = 1'b1;
          end else if (!s_we) begin
            rdata_v[win] = ld_ext;
          end else if (s_f3 == 3'b010) begin
            mem_we = 1'b1;
            mem_wd = s_wdata;
          end else begin
            state_d    = StRmwWr;
            rmw_idx_d  = word_idx;
            rmw_data_d = merged;
          end
        end
      end
      StRmwWr: begin
        mem_a   = rmw_idx_q;
        mem_we  = 1'b1;
        mem_wd  = rmw_data_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Reset must silence the write strobe even before the state register clears.
    if (!rst_n) begin
      gnt_v   = '0;
      err_v   = '0;
      rdata_v = '0;
      mem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_q       <= 1'b0;
      rmw_idx_q  <= '0;
      rmw_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      rmw_idx_q  <= rmw_idx_d;
      rmw_data_q <= rmw_data_d;
    end
  end

  assign p0_gnt   = gnt_v[0];
  assign p1_gnt   = gnt_v[1];
  assign p0_err   = err_v[0];
  assign p1_err   = err_v[1];
  assign p0_rdata = rdata_v[0];
  assign p1_rdata = rdata_v[1];

endmodule
